// File: rtl/pc_ras_pkg.sv
// pc_ras_pkg: shared defaults and helpers for the fetch program counter and its
// return-address stack.
//   DEF_*  : default parameter values used by pc_ras and ras_lifo.
//   clog2  : ceiling log2, used for pointer, count and alignment widths.
package pc_ras_pkg;

    localparam int unsigned DEF_ADDR_W     = 9;
    localparam int unsigned DEF_INSN_BYTES = 4;
    localparam int unsigned DEF_RESET_VEC  = 0;
    localparam int unsigned DEF_RAS_DEPTH  = 4;

    // clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ras_lifo.sv
// ras_lifo: DEPTH x WIDTH last-in first-out stack holding return addresses.
//   i_clk        : rising-edge clock
//   i_rst        : synchronous active-high reset (empties the stack)
//   i_push       : write i_push_data on top (ignored when full)
//   i_pop        : discard the top entry (ignored when empty)
//   i_push_data  : value to push
//   o_top_data   : most recently pushed, not yet popped entry
//   o_count      : number of valid entries (0..DEPTH)
//   o_full       : o_count == DEPTH
//   o_empty      : o_count == 0
// The caller never asserts i_push and i_pop together.
module ras_lifo
    import pc_ras_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RAS_DEPTH,
    parameter int unsigned WIDTH = DEF_ADDR_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_push_data,
    output logic [WIDTH-1:0]       o_top_data,
    output logic [clog2(DEPTH):0]  o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so the low count bits address the next free
    // slot; when full they wrap to 0 and top (minus one) is DEPTH-1.
    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_top_idx = r_count[PTR_W-1:0] - 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + 1'b1;
        end else if (w_do_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Entry contents are don't-care after reset, so the array is not cleared.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    assign o_top_data = r_mem[w_top_idx];
    assign o_count    = r_count;

endmodule

// File: rtl/pc_ras.sv
// pc_ras: fetch program counter with stall, absolute branch and call/return
// through an internal return-address stack.
//   i_clk           : rising-edge clock
//   i_rst           : synchronous active-high reset, wins over everything
//   i_stall         : hold all state; control inputs this cycle are ignored
//   i_branch        : jump to aligned i_branch_adrx
//   i_call          : jump to aligned i_branch_adrx, push o_pc_plus
//   i_ret           : pop the stack and jump to the popped address
//   i_branch_adrx   : branch/call target
//   o_pc            : registered fetch address
//   o_pc_plus       : o_pc + INSN_BYTES, wraps modulo 2^ADDR_W
//   o_ras_count     : valid stack entries
//   o_ras_overflow  : sticky, call while stack full
//   o_ras_underflow : sticky, ret while stack empty
// Priority when not stalled: ret > call > branch > sequential.
module pc_ras
    import pc_ras_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned INSN_BYTES = DEF_INSN_BYTES,
    parameter int unsigned RESET_VEC  = DEF_RESET_VEC,
    parameter int unsigned RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_stall,
    input  logic                       i_branch,
    input  logic                       i_call,
    input  logic                       i_ret,
    input  logic [ADDR_W-1:0]          i_branch_adrx,
    output logic [ADDR_W-1:0]          o_pc,
    output logic [ADDR_W-1:0]          o_pc_plus,
    output logic [clog2(RAS_DEPTH):0]  o_ras_count,
    output logic                       o_ras_overflow,
    output logic                       o_ras_underflow
);

    localparam int unsigned OFF_W = clog2(INSN_BYTES);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INSN_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_d;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_top_data;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_do_ret;
    logic              w_do_call;
    logic              w_do_branch;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign o_pc_plus = r_pc + INC;
    assign w_aligned = i_branch_adrx & ~LOW_MASK;

    // One action per cycle; lower-priority requests are simply dropped.
    assign w_do_ret    = !i_stall && i_ret;
    assign w_do_call   = !i_stall && i_call && !i_ret;
    assign w_do_branch = !i_stall && i_branch && !i_call && !i_ret;

    assign w_push = w_do_call && !w_full;
    assign w_pop  = w_do_ret && !w_empty;

    ras_lifo #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras_lifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (o_pc_plus),
        .o_top_data  (w_top_data),
        .o_count     (o_ras_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_pc_d = o_pc_plus;
        if (i_stall) begin
            w_pc_d = r_pc;
        end else if (w_do_ret) begin
            // An empty-stack ret falls through sequentially.
            w_pc_d = w_empty ? o_pc_plus : w_top_data;
        end else if (w_do_call || w_do_branch) begin
            w_pc_d = w_aligned;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= ADDR_W'(RESET_VEC);
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc <= w_pc_d;
            if (w_do_call && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_do_ret && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_pc            = r_pc;
    assign o_ras_overflow  = r_overflow;
    assign o_ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed stimulus with hand-computed expectations pushed into a
// scoreboard queue; an independent monitor pops and compares one entry after
// every rising edge.
module tb_pc_ras;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       branch;
    logic       call;
    logic       ret;
    logic [8:0] branch_adrx;
    logic [8:0] pc;
    logic [8:0] pc_plus;
    logic [2:0] ras_count;
    logic       ras_overflow;
    logic       ras_underflow;

    typedef struct {
        logic [8:0] pc;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pc_ras #(
        .ADDR_W     (9),
        .INSN_BYTES (4),
        .RESET_VEC  (0),
        .RAS_DEPTH  (4)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_branch        (branch),
        .i_call          (call),
        .i_ret           (ret),
        .i_branch_adrx   (branch_adrx),
        .o_pc            (pc),
        .o_pc_plus       (pc_plus),
        .o_ras_count     (ras_count),
        .o_ras_overflow  (ras_overflow),
        .o_ras_underflow (ras_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input string field,
                         input logic [8:0] act, input logic [8:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%03h, expected 0x%03h", name, field, act, req);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, "pc", pc, e.pc);
                check(e.name, "pcPlus", pc_plus, e.pc + 9'd4);
                check(e.name, "rasCount", {6'd0, ras_count}, {6'd0, e.cnt});
                check(e.name, "rasOverflow", {8'd0, ras_overflow}, {8'd0, e.ovf});
                check(e.name, "rasUnderflow", {8'd0, ras_underflow}, {8'd0, e.unf});
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after that edge.
    task automatic step(input string name, input logic r, input logic s,
                        input logic b, input logic c, input logic t,
                        input logic [8:0] adrx, input logic [8:0] e_pc,
                        input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        rst         = r;
        stall       = s;
        branch      = b;
        call        = c;
        ret         = t;
        branch_adrx = adrx;
        e.pc   = e_pc;
        e.cnt  = e_cnt;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        branch_adrx = '0;

        //    name          rst s  b  c  t  adrx    pc      cnt ovf unf
        // Sequential and wrap
        step("reset",       1, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
        step("seq1",        0, 0, 0, 0, 0, 9'h000, 9'h004, 0, 0, 0);
        step("seq2",        0, 0, 0, 0, 0, 9'h000, 9'h008, 0, 0, 0);
        step("seq3",        0, 0, 0, 0, 0, 9'h000, 9'h00C, 0, 0, 0);
        step("br_1fc",      0, 0, 1, 0, 0, 9'h1FC, 9'h1FC, 0, 0, 0);
        step("wrap",        0, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
        // Branch, stall, alignment
        step("br_align",    0, 0, 1, 0, 0, 9'h0A7, 9'h0A4, 0, 0, 0);
        step("stall1",      0, 1, 1, 0, 0, 9'h100, 9'h0A4, 0, 0, 0);
        step("stall2",      0, 1, 1, 0, 0, 9'h100, 9'h0A4, 0, 0, 0);
        step("stall3",      0, 1, 1, 0, 0, 9'h100, 9'h0A4, 0, 0, 0);
        step("unstall",     0, 0, 0, 0, 0, 9'h000, 9'h0A8, 0, 0, 0);
        // Stalled call/ret must not touch the stack
        step("stall_call",  0, 1, 0, 1, 0, 9'h040, 9'h0A8, 0, 0, 0);
        step("stall_ret",   0, 1, 0, 0, 1, 9'h000, 9'h0A8, 0, 0, 0);
        // Call/return round trip
        step("br_010",      0, 0, 1, 0, 0, 9'h010, 9'h010, 0, 0, 0);
        step("call_080",    0, 0, 0, 1, 0, 9'h080, 9'h080, 1, 0, 0);
        step("idle_084",    0, 0, 0, 0, 0, 9'h000, 9'h084, 1, 0, 0);
        step("idle_088",    0, 0, 0, 0, 0, 9'h000, 9'h088, 1, 0, 0);
        step("ret_014",     0, 0, 0, 0, 1, 9'h000, 9'h014, 0, 0, 0);
        // Overflow: fifth call's push (0x164) is dropped
        step("rst_ov",      1, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
        step("call_100",    0, 0, 0, 1, 0, 9'h100, 9'h100, 1, 0, 0);
        step("call_120",    0, 0, 0, 1, 0, 9'h120, 9'h120, 2, 0, 0);
        step("call_140",    0, 0, 0, 1, 0, 9'h140, 9'h140, 3, 0, 0);
        step("call_160",    0, 0, 0, 1, 0, 9'h160, 9'h160, 4, 0, 0);
        step("call_180",    0, 0, 0, 1, 0, 9'h180, 9'h180, 4, 1, 0);
        step("ret_a",       0, 0, 0, 0, 1, 9'h000, 9'h144, 3, 1, 0);
        step("ret_b",       0, 0, 0, 0, 1, 9'h000, 9'h124, 2, 1, 0);
        step("ret_c",       0, 0, 0, 0, 1, 9'h000, 9'h104, 1, 1, 0);
        step("ret_d",       0, 0, 0, 0, 1, 9'h000, 9'h004, 0, 1, 0);
        // Underflow and priority
        step("rst_un",      1, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0);
        step("br_020",      0, 0, 1, 0, 0, 9'h020, 9'h020, 0, 0, 0);
        step("ret_empty",   0, 0, 0, 0, 1, 9'h000, 9'h024, 0, 0, 1);
        step("br_0ec",      0, 0, 1, 0, 0, 9'h0EC, 9'h0EC, 0, 0, 1);
        step("call_040",    0, 0, 0, 1, 0, 9'h040, 9'h040, 1, 0, 1);
        step("prio_ret",    0, 0, 1, 1, 1, 9'h1A0, 9'h0F0, 0, 0, 1);
        step("prio_call",   0, 0, 1, 1, 0, 9'h1A3, 9'h1A0, 1, 0, 1);
        step("ret_0f4",     0, 0, 0, 0, 1, 9'h000, 9'h0F4, 0, 0, 1);
        // Call then immediate ret, and wrapped return address
        step("call_1fc",    0, 0, 0, 1, 0, 9'h1FC, 9'h1FC, 1, 0, 1);
        step("ret_0f8",     0, 0, 0, 0, 1, 9'h000, 9'h0F8, 0, 0, 1);
        step("br_1fc_b",    0, 0, 1, 0, 0, 9'h1FC, 9'h1FC, 0, 0, 1);
        step("call_wrap",   0, 0, 0, 1, 0, 9'h100, 9'h100, 1, 0, 1);
        step("ret_wrap",    0, 0, 0, 0, 1, 9'h000, 9'h000, 0, 0, 1);
        // Reset mid-operation
        step("call_050",    0, 0, 0, 1, 0, 9'h050, 9'h050, 1, 0, 1);
        step("call_060",    0, 0, 0, 1, 0, 9'h060, 9'h060, 2, 0, 1);
        step("rst_ret",     1, 0, 0, 0, 1, 9'h000, 9'h000, 0, 0, 0);
        step("ret_after",   0, 0, 0, 0, 1, 9'h000, 9'h004, 0, 0, 1);
        step("idle_end",    0, 0, 0, 0, 0, 9'h000, 9'h008, 0, 0, 1);

        // Let the monitor drain; a stuck queue counts as a failure.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
